// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and constants for the data-memory responder
package data_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              err;
    } rsp_t;

    localparam rsp_t ERR_RSP = '{rdata: '0, err: 1'b1};

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle for the responder
interface data_mem_responder_if;
    import data_mem_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [31:0]       req_addr_i;
    logic [BE_W-1:0]   req_be_i;
    logic [WORD_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [WORD_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_be_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_be_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with per-byte synchronous write and combinational read
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with programmable latency
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic                clk_i,
    input logic                rst_i,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [31:0]       lat_addr;
    logic [BE_W-1:0]   lat_be;
    logic [WORD_W-1:0] lat_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              addr_err;
    logic              access;
    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;

    assign addr_err = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (IDX_W + 2)) != 32'd0);
    assign access   = (state == BUSY) && (cnt == '0);
    // A reset landing on the access edge must not let the store commit.
    assign arr_we   = access && lat_write && !addr_err && !rst_i;

    data_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .we    (arr_we),
        .idx   (lat_addr[2 +: IDX_W]),
        .be    (lat_be),
        .wdata (lat_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        lat_write <= bus.req_write_i;
                        lat_addr  <= bus.req_addr_i;
                        lat_be    <= bus.req_be_i;
                        lat_wdata <= bus.req_wdata_i;
                        cnt       <= CNT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (addr_err) begin
                            {rsp_rdata, rsp_err} <= ERR_RSP;
                        end else begin
                            rsp_rdata <= lat_write ? '0 : arr_rdata;
                            rsp_err   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.rsp_err_o   = rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] model [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_req", bus.req_ready_o, 1);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = w;
        bus.req_addr_i  = a;
        bus.req_be_i    = be;
        bus.req_wdata_i = d;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'($urandom);
        bus.req_addr_i  = $urandom;
        bus.req_be_i    = 4'($urandom);
        bus.req_wdata_i = $urandom;
        lat = 0;
        while (!bus.rsp_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_seen", bus.rsp_valid_o, 1);
        rd = bus.rsp_rdata_o;
        er = bus.rsp_err_o;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("rsp_valid_cleared", bus.rsp_valid_o, 0);
        check("rsp_rdata_cleared", bus.rsp_rdata_o, 0);
        check("req_ready_after_rsp", bus.req_ready_o, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;

        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_be_i     = '0;
        bus.req_wdata_i  = '0;
        bus.rsp_ready_i  = 1'b0;
        bus1.req_valid_i = 1'b0;
        bus1.req_write_i = 1'b0;
        bus1.req_addr_i  = '0;
        bus1.req_be_i    = '0;
        bus1.req_wdata_i = '0;
        bus1.rsp_ready_i = 1'b0;

        // Request presented during reset must be ignored.
        bus.req_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst = 1'b0;
        check("reset_req_ready", bus.req_ready_o, 1);
        check("reset_rsp_valid", bus.rsp_valid_o, 0);
        check("reset_rsp_rdata", bus.rsp_rdata_o, 0);
        check("reset_rsp_err", bus.rsp_err_o, 0);

        vecs.push_back('{1'b1, 32'h10,  4'b1111, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,  4'b0000, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h10,  4'b0101, 32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,  4'b1111, 32'h0,        32'hDE22BE44, 1'b0});
        vecs.push_back('{1'b0, 32'h13,  4'b1111, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0,   4'b1111, 32'h12345678, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h400, 4'b1111, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0,   4'b0000, 32'h0,        32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 32'h4,   4'b1111, 32'hAAAAAAAA, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h4,   4'b0000, 32'h55555555, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h4,   4'b0000, 32'h0,        32'hAAAAAAAA, 1'b0});
        vecs.push_back('{1'b1, 32'h3FC, 4'b1111, 32'h0BADF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h3FC, 4'b0000, 32'h0,        32'h0BADF00D, 1'b0});
        vecs.push_back('{1'b1, 32'h6,   4'b1111, 32'h99999999, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'hFFFFFFFC, 4'b0000, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h4,   4'b0000, 32'h0,        32'hAAAAAAAA, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].w, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            check($sformatf("vec%0d_latency", i), lat, 2);
        end

        // Response backpressure: hold rsp_ready low for five cycles.
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = 32'h10;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        lat = 0;
        while (!bus.rsp_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid_hold", bus.rsp_valid_o, 1);
            check("bp_rsp_rdata_hold", bus.rsp_rdata_o, 32'hDE22BE44);
            check("bp_req_ready_low", bus.req_ready_o, 0);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check("bp_rsp_valid_drop", bus.rsp_valid_o, 0);
        check("bp_req_ready_rise", bus.req_ready_o, 1);

        // Reset mid-operation, both one edge before and on the access edge.
        for (int k = 0; k < 2; k++) begin
            txn(1'b1, 32'h20, 4'b1111, 32'h55AA55AA, rd, er, lat);
            @(negedge clk);
            bus.req_valid_i = 1'b1;
            bus.req_write_i = 1'b1;
            bus.req_addr_i  = 32'h20;
            bus.req_be_i    = 4'b1111;
            bus.req_wdata_i = 32'hCAFEF00D;
            @(negedge clk);
            bus.req_valid_i = 1'b0;
            if (k == 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check($sformatf("midrst%0d_req_ready", k), bus.req_ready_o, 1);
            seen = 1'b0;
            for (int c = 0; c < 5; c++) begin
                if (bus.rsp_valid_o) seen = 1'b1;
                @(negedge clk);
            end
            check($sformatf("midrst%0d_no_rsp", k), seen, 0);
            txn(1'b0, 32'h20, 4'b0000, 32'h0, rd, er, lat);
            check($sformatf("midrst%0d_load", k), rd, 32'h55AA55AA);
        end

        // Randomised traffic against a byte-level model of words 0..15.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(1'b1, 32'(i * 4), 4'b1111, model[i], rd, er, lat);
        end
        for (int i = 0; i < 60; i++) begin
            logic        w;
            logic [31:0] a;
            logic [3:0]  be;
            logic [31:0] d;
            logic [31:0] exp_rd;
            logic        exp_er;
            int          idx;
            int          kind;
            w    = 1'($urandom);
            be   = 4'($urandom);
            d    = $urandom;
            idx  = $urandom_range(0, 15);
            kind = $urandom_range(0, 9);
            if (kind == 0) a = 32'(idx * 4 + $urandom_range(1, 3));
            else if (kind == 1) a = 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
            else a = 32'(idx * 4);
            exp_er = (a % 4 != 0) || (a >= 4 * DEPTH);
            exp_rd = 32'h0;
            if (!exp_er) begin
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
                end else begin
                    exp_rd = model[a / 4];
                end
            end
            txn(w, a, be, d, rd, er, lat);
            check($sformatf("rand%0d_rdata", i), rd, exp_rd);
            check($sformatf("rand%0d_err", i), er, exp_er);
            check($sformatf("rand%0d_latency", i), lat, 2);
        end

        // LATENCY=1 instance: back-to-back stores with rsp_ready tied high.
        begin
            int acc[$];
            int pulses;
            logic prev_valid;
            logic double_valid;
            pulses       = 0;
            prev_valid   = 1'b0;
            double_valid = 1'b0;
            @(negedge clk);
            bus1.rsp_ready_i = 1'b1;
            bus1.req_valid_i = 1'b1;
            bus1.req_write_i = 1'b1;
            bus1.req_addr_i  = 32'h40;
            bus1.req_be_i    = 4'b1111;
            for (int c = 0; c < 30; c++) begin
                bus1.req_wdata_i = 32'(c);
                if (bus1.req_ready_o) acc.push_back(c);
                if (bus1.rsp_valid_o) begin
                    if (prev_valid) double_valid = 1'b1;
                    else pulses++;
                end
                prev_valid = bus1.rsp_valid_o;
                @(negedge clk);
            end
            bus1.req_valid_i = 1'b0;
            check("l1_accept_count", acc.size(), 10);
            for (int i = 1; i < acc.size(); i++)
                check($sformatf("l1_gap%0d", i), acc[i] - acc[i-1], 3);
            check("l1_single_cycle_valid", double_valid, 0);
            check("l1_pulse_count", pulses, 10);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU's data-memory port. Accepts one load/store request at a time over a valid/ready handshake. Performs the access after a programmable latency against an internal word array. Returns read data, or a write acknowledge, over a second valid/ready handshake. Sits between the MEM pipeline stage and data storage, and lets the pipeline be tested against non-zero memory latency.

## Interface
- DEPTH, 256: number of 32-bit words stored; power of two, ≥ 2.
- LATENCY, 2: cycles from request acceptance to response valid; ≥ 1.
- clk_i  input  1  single clock, all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_be_i  input  4  byte enables for stores; bit n covers bits [8n+7:8n]; ignored for loads.
- req_wdata_i  input  32  store data.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer accepts response.
- rsp_rdata_o  output  32  load data; 0 for stores and errors.
- rsp_err_o  output  1  request was misaligned or out of range.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: req_ready_o = 1. On req_valid_i at an edge, the responder:
  - latches write, addr, be and wdata;
  - loads the counter with LATENCY-1;
  - moves to BUSY.
- BUSY: req_ready_o = 0. The counter decrements at each edge. At the edge where counter = 0, the responder performs the access, registers the response and moves to RESP.
- RESP: rsp_valid_o = 1. rsp_rdata_o and rsp_err_o stay stable until handshake. The edge with rsp_ready_i = 1 moves to IDLE and clears rsp_valid_o, rsp_rdata_o and rsp_err_o.
- Index = addr[2 +: log2(DEPTH)].
- Error if addr[1:0] ≠ 0 or addr ≥ 4·DEPTH. On error, no array write occurs, rsp_rdata_o = 0 and rsp_err_o = 1.
- Store: bytes with be = 1 are written. be = 4'b0000 is a legal no-op and still gets a response. rsp_rdata_o = 0.
- Load: returns the full word from the array at the access edge, so it sees every store committed earlier.
- Only one request is outstanding at a time. A request can never be accepted in the same cycle as a response handshake.
- The array is not cleared by reset. Its contents persist across reset.

## Timing
- Reset values (after the reset edge): state IDLE, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, counter = 0.
- While rst_i is high, req_valid_i is ignored.
- Request accepted at edge t: rsp_valid_o is high after edge t+LATENCY. The store commits at that same edge.
- Response accepted at edge r: req_ready_o is high after r. The next request can be accepted at edge r+1.
- Minimum throughput is LATENCY+2 cycles per request.
- rsp_ready_i held high before the response appears: handshake completes on the first edge in RESP, so rsp_valid_o is high for exactly one cycle.
- Reset mid-operation (BUSY or RESP):
  - the pending request is dropped;
  - an uncommitted store is never written;
  - no response is produced;
  - state returns to IDLE.
- Request inputs may change freely after acceptance. Only latched copies are used.

## Structure
- Package data_mem_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the word width (32) and byte-enable width (4);
  - the error-response constant (rdata 0, err 1).
- Sub-module data_mem_array:
  - DEPTH×32 storage;
  - synchronous per-byte write with enable;
  - combinational read by index.
- FSM, counter, address checking and response registers live in the top.

## Test plan
- Reset, then store: addr 0x10, wdata 0xDEADBEEF, be 4'b1111, LATENCY 2. Response: rsp_valid_o high after acceptance edge +2, rsp_err_o = 0, rsp_rdata_o = 0.
- Load: addr 0x10 → rsp_rdata_o = 0xDEADBEEF.
- Partial store: be 4'b0101, wdata 0x11223344 to addr 0x10, then load addr 0x10 → 0xDE22BE44.
- Misaligned load at addr 0x13 → rsp_err_o = 1, rsp_rdata_o = 0.
- Out-of-range store at addr 4·DEPTH → rsp_err_o = 1; a following load from index 0 is unchanged.
- Response backpressure:
  - hold rsp_ready_i = 0 for 5 cycles: rsp_valid_o and rsp_rdata_o stay stable and req_ready_o stays 0;
  - raise rsp_ready_i: rsp_valid_o drops after that edge and req_ready_o rises.
- Reset mid-operation: assert rst_i in BUSY during a store of 0xCAFEF00D to addr 0x20. No response appears, req_ready_o = 1 after the reset edge, and a later load of addr 0x20 returns the pre-store value.
- LATENCY = 1 build: back-to-back requests with rsp_ready_i tied high are accepted every 3 cycles.
